// File: rtl/img_proc_pkg.sv
// Shared image-pipeline constants, width helper and
// centroid FSM state encoding.
package img_proc_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  function automatic int clog2(input longint n);
    int r;
    longint v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int XW_DEF = clog2(IMG_W_DEF);
  localparam int YW_DEF = clog2(IMG_H_DEF);
  localparam int CW_DEF =
    clog2(longint'(IMG_W_DEF) * IMG_H_DEF + 1);
  localparam int SUM_W_DEF =
    clog2(longint'(IMG_W_DEF) * IMG_H_DEF
          * (IMG_W_DEF - 1) + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIV_X,
    ST_DIV_Y,
    ST_DONE
  } cl_state_t;

endpackage

// File: rtl/centroid_divider.sv
// Serial restoring divider, one quotient bit per cycle;
// the start cycle already performs the first iteration.
module centroid_divider
  import img_proc_pkg::*;
#(
  parameter int NW = 9,
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] quotient
);

  localparam int CNTW = clog2(NW + 1);

  logic [DW-1:0]   rem;
  logic [DW-1:0]   dvs;
  logic [CNTW-1:0] cnt;

  logic [DW-1:0] rem_src;
  logic [DW-1:0] dvs_src;
  logic [NW-1:0] q_src;
  logic [DW:0]   shifted;
  logic [DW:0]   diff;
  logic          fit;
  logic [DW-1:0] rem_nx;
  logic [NW-1:0] q_nx;

  always_comb begin
    rem_src = start ? '0 : rem;
    q_src   = start ? dividend : quotient;
    dvs_src = start ? divisor : dvs;
    shifted = {rem_src, q_src[NW-1]};
    diff    = shifted - {1'b0, dvs_src};
    fit     = shifted >= {1'b0, dvs_src};
    rem_nx  = fit ? diff[DW-1:0] : shifted[DW-1:0];
    q_nx    = {q_src[NW-2:0], fit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= rem_nx;
        quotient <= q_nx;
        dvs      <= divisor;
        cnt      <= CNTW'(NW - 1);
        busy     <= 1'b1;
      end else if (busy) begin
        rem      <= rem_nx;
        quotient <= q_nx;
        cnt      <= cnt - CNTW'(1);
        if (cnt == CNTW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/binary_centroid_locator.sv
// Per-frame foreground centroid/count locator.
// Define CENTROID_BBOX_EN to build the bounding-box trackers.
module binary_centroid_locator
  import img_proc_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int MIN_PIX = 16,
  localparam int XW = clog2(IMG_W),
  localparam int YW = clog2(IMG_H),
  localparam int CW =
    clog2(longint'(IMG_W) * IMG_H + 1),
  localparam int SUM_W =
    clog2(longint'(IMG_W) * IMG_H * (IMG_W - 1) + 1)
) (
  input  logic          clk_i,
  input  logic          a_rst_i,
  input  logic          i_hsyn,
  input  logic          i_vsyn,
  input  logic          i_en,
  input  logic [7:0]    i_binary,
  output logic          o_valid,
  output logic          o_found,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic [CW-1:0] o_cnt,
  output logic [XW-1:0] o_xmin,
  output logic [XW-1:0] o_xmax,
  output logic [YW-1:0] o_ymin,
  output logic [YW-1:0] o_ymax,
  output logic          o_overrun
);

  localparam logic [XW:0] X_LIM = (XW+1)'(IMG_W);
  localparam logic [YW:0] Y_LIM = (YW+1)'(IMG_H);
  localparam logic [CW:0] MIN_C = (CW+1)'(MIN_PIX);

  cl_state_t state;
  cl_state_t state_n;

  logic          vsyn_q;
  logic          en_q;
  logic          edge_c;
  logic          snap_c;
  logic          pix_c;
  logic [XW:0]   x;
  logic [YW:0]   y;
  logic [XW-1:0] xc;
  logic [YW-1:0] yc;

  assign edge_c = i_vsyn & ~vsyn_q;
  assign snap_c = edge_c & (state == ST_IDLE);
  assign xc     = x[XW-1:0];
  assign yc     = y[YW-1:0];
  assign pix_c  = i_en & i_binary[0] & ~edge_c
                & (x < X_LIM) & (y < Y_LIM);

  // x/y saturate one past the window so stray pixels never wrap in
  always_ff @(posedge clk_i or negedge a_rst_i) begin
    if (!a_rst_i) begin
      vsyn_q <= 1'b0;
      en_q   <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else begin
      vsyn_q <= i_vsyn;
      en_q   <= i_en;
      if (edge_c) begin
        x <= '0;
        y <= '0;
      end else if (i_en) begin
        if (x != X_LIM) x <= x + (XW+1)'(1);
      end else if (en_q) begin
        x <= '0;
        if (y != Y_LIM) y <= y + (YW+1)'(1);
      end
    end
  end

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    s_cnt;
  logic [SUM_W-1:0] sx;
  logic [SUM_W-1:0] sy;
  logic [SUM_W-1:0] s_sx;
  logic [SUM_W-1:0] s_sy;

  always_ff @(posedge clk_i or negedge a_rst_i) begin
    if (!a_rst_i) begin
      cnt   <= '0;
      sx    <= '0;
      sy    <= '0;
      s_cnt <= '0;
      s_sx  <= '0;
      s_sy  <= '0;
    end else begin
      if (edge_c) begin
        cnt <= '0;
        sx  <= '0;
        sy  <= '0;
      end else if (pix_c) begin
        cnt <= cnt + CW'(1);
        sx  <= sx + SUM_W'(xc);
        sy  <= sy + SUM_W'(yc);
      end
      if (snap_c) begin
        s_cnt <= cnt;
        s_sx  <= sx;
        s_sy  <= sy;
      end
    end
  end

  logic [XW-1:0] s_xmin;
  logic [XW-1:0] s_xmax;
  logic [YW-1:0] s_ymin;
  logic [YW-1:0] s_ymax;

`ifdef CENTROID_BBOX_EN
  logic [XW-1:0] xmin;
  logic [XW-1:0] xmax;
  logic [YW-1:0] ymin;
  logic [YW-1:0] ymax;

  // cleared to zero each frame so an empty frame reports a zero box
  always_ff @(posedge clk_i or negedge a_rst_i) begin
    if (!a_rst_i) begin
      xmin   <= '0;
      xmax   <= '0;
      ymin   <= '0;
      ymax   <= '0;
      s_xmin <= '0;
      s_xmax <= '0;
      s_ymin <= '0;
      s_ymax <= '0;
    end else begin
      if (edge_c) begin
        xmin <= '0;
        xmax <= '0;
        ymin <= '0;
        ymax <= '0;
      end else if (pix_c) begin
        if (cnt == '0) begin
          xmin <= xc;
          xmax <= xc;
          ymin <= yc;
          ymax <= yc;
        end else begin
          if (xc < xmin) xmin <= xc;
          if (xc > xmax) xmax <= xc;
          if (yc < ymin) ymin <= yc;
          if (yc > ymax) ymax <= yc;
        end
      end
      if (snap_c) begin
        s_xmin <= xmin;
        s_xmax <= xmax;
        s_ymin <= ymin;
        s_ymax <= ymax;
      end
    end
  end
`else
  assign s_xmin = '0;
  assign s_xmax = '0;
  assign s_ymin = '0;
  assign s_ymax = '0;
`endif

  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [SUM_W-1:0] div_a;
  logic [SUM_W-1:0] div_q;

  centroid_divider #(
    .NW(SUM_W),
    .DW(CW)
  ) u_div (
    .clk     (clk_i),
    .rst_n   (a_rst_i),
    .start   (div_start),
    .dividend(div_a),
    .divisor (s_cnt),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_q)
  );

  logic          found;
  logic          found_n;
  logic [XW-1:0] qx;
  logic [XW-1:0] qx_n;
  logic [YW-1:0] qy;
  logic [YW-1:0] qy_n;
  logic          r_v;
  logic          res_v_n;

  always_comb begin
    state_n   = state;
    div_start = 1'b0;
    div_a     = s_sx;
    found_n   = found;
    qx_n      = qx;
    qy_n      = qy;
    res_v_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (edge_c) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        if ({1'b0, s_cnt} < MIN_C) begin
          found_n = 1'b0;
          state_n = ST_DONE;
        end else begin
          found_n   = 1'b1;
          div_start = 1'b1;
          state_n   = ST_DIV_X;
        end
      end
      ST_DIV_X: begin
        if (div_done) begin
          qx_n      = div_q[XW-1:0];
          div_a     = s_sy;
          div_start = 1'b1;
          state_n   = ST_DIV_Y;
        end
      end
      ST_DIV_Y: begin
        if (div_done) begin
          qy_n    = div_q[YW-1:0];
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        res_v_n = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // qx/qy only change on a found frame, so they double as the held centroid
  always_ff @(posedge clk_i or negedge a_rst_i) begin
    if (!a_rst_i) begin
      state     <= ST_IDLE;
      found     <= 1'b0;
      qx        <= '0;
      qy        <= '0;
      r_v       <= 1'b0;
      o_valid   <= 1'b0;
      o_found   <= 1'b0;
      o_x       <= '0;
      o_y       <= '0;
      o_cnt     <= '0;
      o_xmin    <= '0;
      o_xmax    <= '0;
      o_ymin    <= '0;
      o_ymax    <= '0;
      o_overrun <= 1'b0;
    end else begin
      state     <= state_n;
      found     <= found_n;
      qx        <= qx_n;
      qy        <= qy_n;
      r_v       <= res_v_n;
      o_valid   <= r_v;
      o_overrun <= edge_c & (state != ST_IDLE);
      if (r_v) begin
        o_found <= found;
        o_x     <= qx;
        o_y     <= qy;
        o_cnt   <= s_cnt;
        o_xmin  <= s_xmin;
        o_xmax  <= s_xmax;
        o_ymin  <= s_ymin;
        o_ymax  <= s_ymax;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{i_hsyn, i_binary[7:1],
                       div_busy, div_q};

endmodule
